// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and the
// default stall timeout for the 50 MHz board clock.
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } meter_state_t;

  // One second of the 50 MHz board clock.
  localparam int unsigned DEFAULT_TIMEOUT = 50_000_000;

endpackage

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle
// rise/fall strobes derived from the synchronized level.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync    <= '0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], d_async};
      level_d <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures high time, low time and period of a slow asynchronous input in
// clk cycles, pulsing valid once per complete period and flagging stalls.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clear,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] low_time,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  logic level, rise, fall, edge_seen, timeout_hit;
  meter_state_t state, state_next;
  logic [WIDTH-1:0] hcnt, lcnt, hlat, tcnt;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_async(sig_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign edge_seen = rise | fall;
  // An edge in the same cycle the timeout would expire always wins.
  assign timeout_hit = !edge_seen && (tcnt == TIMEOUT_W - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_RISE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (clear || timeout_hit) begin
      state_next = WAIT_RISE;
    end else begin
      unique case (state)
        WAIT_RISE: if (rise) state_next = HIGH;
        HIGH:      if (fall) state_next = LOW;
        LOW:       if (rise) state_next = HIGH;
        default:   state_next = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt      <= '0;
      lcnt      <= '0;
      hlat      <= '0;
      tcnt      <= '0;
      high_time <= '0;
      low_time  <= '0;
      period    <= '0;
      valid     <= 1'b0;
      stalled   <= 1'b0;
    end else if (clear) begin
      hcnt      <= '0;
      lcnt      <= '0;
      hlat      <= '0;
      tcnt      <= '0;
      high_time <= '0;
      low_time  <= '0;
      period    <= '0;
      valid     <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block overrides it for this edge.
      valid <= 1'b0;

      if (edge_seen)              tcnt <= '0;
      else if (tcnt != TIMEOUT_W) tcnt <= tcnt + ONE;

      if (timeout_hit) stalled <= 1'b1;
      else if (rise)   stalled <= 1'b0;

      // The edge-detect cycle is cycle 1 of the new phase.
      unique case (state)
        WAIT_RISE: if (rise) hcnt <= ONE;
        HIGH: begin
          if (fall) begin
            hlat <= hcnt;
            lcnt <= ONE;
          end else begin
            hcnt <= hcnt + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            high_time <= hlat;
            low_time  <= lcnt;
            period    <= hlat + lcnt;
            valid     <= 1'b1;
            hcnt      <= ONE;
          end else begin
            lcnt <= lcnt + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Edge strobes must agree with the synchronized level they were derived from.
  a_edge_level: assert property (@(posedge clk) disable iff (!reset)
                                 (rise |-> level) and (fall |-> !level));

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: table-driven waveforms, hand
// sequences for stall/clear/reset, and random waves against a timestamp model.
module tb_clk_period_meter;

  localparam int W  = 32;
  localparam int TO = 1000;
  localparam int S  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sig_in = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] high_time, low_time, period;
  logic         valid, stalled;

  clk_period_meter #(
    .WIDTH      (W),
    .TIMEOUT    (TO),
    .SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .clear    (clear),
    .high_time(high_time),
    .low_time (low_time),
    .period   (period),
    .valid    (valid),
    .stalled  (stalled)
  );

  always #10 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: timestamps of synchronized edges, lengths by subtraction.
  bit q[$];
  bit m_prev, m_armed, m_have_fall, m_valid, m_stalled;
  int m_cyc = 0, m_since, m_t_rise, m_t_fall;
  int m_high, m_low, m_period;

  // Observations of the DUT.
  int           n_valid = 0, last_valid_cyc = 0, last_gap = 0;
  logic [W-1:0] cap_h = '0, cap_l = '0, cap_p = '0;

  typedef struct {
    int hi; int lo; int n;
    int exp_h; int exp_l; int exp_p; int exp_nvalid; int exp_gap;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    q = {};
    for (int i = 0; i < S; i++) q.push_back(1'b0);
    m_prev = 0; m_armed = 0; m_have_fall = 0; m_valid = 0; m_stalled = 0;
    m_since = 0; m_t_rise = 0; m_t_fall = 0;
    m_high = 0; m_low = 0; m_period = 0;
  endtask

  task automatic model_step(input bit v, input bit clr);
    bit e, r, f;
    q.push_back(v);
    e = q.pop_front();
    r = (e != m_prev) && e;
    f = (e != m_prev) && !e;
    m_prev = e;
    m_cyc++;
    m_valid = 0;
    if (clr) begin
      m_armed = 0; m_have_fall = 0; m_stalled = 0; m_since = 0;
      m_high = 0; m_low = 0; m_period = 0;
      return;
    end
    if (r || f) begin
      m_since = 0;
    end else begin
      m_since++;
      if (m_since == TO) begin
        m_stalled = 1; m_armed = 0; m_have_fall = 0;
      end
    end
    if (r) begin
      m_stalled = 0;
      if (m_armed && m_have_fall) begin
        m_high   = m_t_fall - m_t_rise;
        m_low    = m_cyc - m_t_fall;
        m_period = m_high + m_low;
        m_valid  = 1;
      end
      m_armed = 1; m_have_fall = 0; m_t_rise = m_cyc;
    end
    if (f && m_armed && !m_have_fall) begin
      m_have_fall = 1; m_t_fall = m_cyc;
    end
  endtask

  task automatic cycle(input logic v, input logic c);
    sig_in = v;
    clear  = c;
    @(posedge clk);
    #1;
    model_step(v, c);
    check("valid", valid, m_valid);
    check("stalled", stalled, m_stalled);
    check("high_time", high_time, m_high);
    check("low_time", low_time, m_low);
    check("period", period, m_period);
    if (valid) begin
      n_valid++;
      last_gap = m_cyc - last_valid_cyc;
      last_valid_cyc = m_cyc;
      cap_h = high_time; cap_l = low_time; cap_p = period;
    end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) cycle(v, 1'b0);
  endtask

  task automatic apply_wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  initial begin
    int k, first_stall, hi, lo;

    tbl[0] = '{hi: 50, lo: 50, n: 4, exp_h: 50, exp_l: 50, exp_p: 100, exp_nvalid: 3, exp_gap: 100};
    tbl[1] = '{hi: 30, lo: 70, n: 3, exp_h: 30, exp_l: 70, exp_p: 100, exp_nvalid: 3, exp_gap: 100};
    tbl[2] = '{hi: 10, lo: 10, n: 3, exp_h: 10, exp_l: 10, exp_p: 20,  exp_nvalid: 3, exp_gap: 20};
    tbl[3] = '{hi: 1,  lo: 20, n: 3, exp_h: 1,  exp_l: 20, exp_p: 21,  exp_nvalid: 3, exp_gap: 21};
    tbl[4] = '{hi: 7,  lo: 3,  n: 3, exp_h: 7,  exp_l: 3,  exp_p: 10,  exp_nvalid: 3, exp_gap: 10};

    // Reset state.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_stalled", stalled, 0);
    check("rst_high", high_time, 0);
    check("rst_low", low_time, 0);
    check("rst_period", period, 0);
    @(negedge clk);
    reset = 1'b1;

    // Latency: valid appears on the 3rd edge after the closing rise is sampled.
    hold(1'b1, 5);
    hold(1'b0, 5);
    n_valid = 0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("latency_early", n_valid, 0);
    cycle(1'b1, 1'b0);
    check("latency_valid", valid, 1);
    hold(1'b1, 4);
    hold(1'b0, 10);

    // Fresh start for the table so the first row sees a clean rise-fall-rise.
    clear = 1'b0;
    cycle(1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      n_valid = 0;
      apply_wave(tbl[i].hi, tbl[i].lo, tbl[i].n);
      check("tbl_nvalid", n_valid, tbl[i].exp_nvalid);
      check("tbl_high", cap_h, tbl[i].exp_h);
      check("tbl_low", cap_l, tbl[i].exp_l);
      check("tbl_period", cap_p, tbl[i].exp_p);
      check("tbl_gap", last_gap, tbl[i].exp_gap);
    end

    // Stall: stalled rises exactly TO cycles after the last detected edge.
    apply_wave(20, 20, 2);
    hold(1'b1, 20);
    cycle(1'b0, 1'b0);
    k = m_cyc;
    first_stall = -1;
    for (int i = 0; i < TO + 100; i++) begin
      cycle(1'b0, 1'b0);
      if (stalled && first_stall < 0) first_stall = m_cyc;
    end
    check("stall_cycle", first_stall, k + S + TO);
    check("stall_hold_h", high_time, 20);
    check("stall_hold_p", period, 40);
    n_valid = 0;
    hold(1'b1, 4);
    check("stall_cleared", stalled, 0);
    hold(1'b1, 8);
    hold(1'b0, 6);
    hold(1'b1, 4);
    check("stall_resume_nvalid", n_valid, 1);
    check("stall_resume_h", cap_h, 12);
    check("stall_resume_l", cap_l, 6);

    // Clear while HIGH.
    hold(1'b1, 10);
    cycle(1'b1, 1'b1);
    check("clr_valid", valid, 0);
    check("clr_high", high_time, 0);
    check("clr_period", period, 0);
    n_valid = 0;
    hold(1'b1, 3);
    hold(1'b0, 8);
    hold(1'b1, 6);
    hold(1'b0, 4);
    hold(1'b1, 4);
    check("clr_resume_nvalid", n_valid, 1);
    check("clr_resume_p", cap_p, 10);

    // Reset mid-LOW right as valid fires.
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 3);
    check("pre_rst_valid", valid, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_high", high_time, 0);
    check("mid_rst_period", period, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    n_valid = 0;
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 5);
    check("post_rst_nvalid", n_valid, 1);
    check("post_rst_p", cap_p, 10);

    // Randomized waves, including lows straddling the timeout and stray clears.
    for (int p = 0; p < 40; p++) begin
      hi = $urandom_range(60, 1);
      lo = ($urandom_range(7, 0) == 0) ? $urandom_range(TO + 5, TO - 5) : $urandom_range(60, 1);
      if ($urandom_range(15, 0) == 0) begin
        cycle(1'b1, 1'b1);
        hi = hi - 1;
      end
      hold(1'b1, hi);
      hold(1'b0, lo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
